alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
- Multi-word sequencer for the lab ALU and its NZCV flag logic, including the overflow (V) flag path.
- Accepts a command (op, word count), then streams operand word pairs, least-significant word first, through the external combinational ALU one word per beat.
- Chains the carry between words, returns each result word over a valid/ready output, and captures the final N/Z/C/V flags into a flag register.
- Sits between the lab's stimulus or control source and the ALU/flag datapath.

Parameters:
- WIDTH, 4, ALU word width in bits.
- MAX_WORDS, 4, maximum words per operation; LW = $clog2(MAX_WORDS).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  controller idle, command accepted when both high.
- cmd_op  input  2  00 ADD, 01 SUB, 10 AND, 11 OR.
- cmd_len  input  LW  word count minus 1.
- in_valid  input  1  operand word pair offered.
- in_ready  output  1  word pair accepted when both high.
- in_a  input  WIDTH  operand A word.
- in_b  input  WIDTH  operand B word.
- alu_a  output  WIDTH  to ALU, equals in_a (combinational).
- alu_b  output  WIDTH  to ALU, equals in_b (combinational).
- alu_op  output  2  to ALU, registered op.
- alu_cin  output  1  to ALU carry-in.
- alu_y  input  WIDTH  ALU result.
- alu_cout  input  1  ALU carry-out (SUB convention: 1 = no borrow).
- alu_v  input  1  ALU overflow from flag V logic.
- out_valid  output  1  result word valid.
- out_ready  input  1  downstream accepts result word.
- out_y  output  WIDTH  result word.
- out_last  output  1  marks final word of the operation.
- flags  output  4  {N,Z,C,V}, held until next operation completes.
- flags_valid  output  1  one-cycle pulse when flags update.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - cmd_ready = 1; in_ready, out_valid, out_last, flags_valid = 0.
  - out_y = 0, flags = 4'b0100 (Z set), carry register = 0, word counter = 0, zero accumulator = 1.
- State IDLE:
  - cmd_ready = 1.
  - On cmd_valid: latch op and len, counter = 0, zero accumulator = 1.
  - Carry register = 1 for SUB, else 0.
  - Transition to RUN.
- State RUN:
  - cmd_ready = 0.
  - in_ready = !out_valid || out_ready (single-entry output register; back-to-back words allowed).
  - alu_cin = carry register for ADD/SUB, 0 for AND/OR.
- On an in-beat (in_valid && in_ready):
  - out_y <= alu_y; out_valid <= 1.
  - out_last <= (counter == len).
  - carry register <= alu_cout.
  - zero accumulator <= acc && (alu_y == 0).
  - counter increments.
  - Latency: result word appears exactly 1 cycle after acceptance.
- Final beat (counter == len):
  - flags <= {alu_y[WIDTH-1], acc && (alu_y==0), C, V}.
  - For ADD/SUB: C = alu_cout, V = alu_v. For AND/OR: C = 0, V = 0.
  - flags_valid pulses the following cycle (aligned with out_last word becoming valid).
  - State -> DRAIN.
- State DRAIN:
  - in_ready = 0.
  - Wait until the last word is accepted (out_valid && out_ready), then -> IDLE; cmd_ready rises the next cycle.
- Output handshake:
  - out_valid, out_y, out_last hold stable while out_valid && !out_ready.
  - out_valid clears on acceptance unless a new in-beat loads the same cycle.
- Boundary conditions:
  - cmd_len = 0 is a single-word operation.
  - Intermediate words never update flags; V is taken from the most-significant word only.
  - cmd_valid outside IDLE is ignored (cmd_ready low).
  - in_valid in IDLE or DRAIN is ignored.
  - rst_n asserted mid-operation aborts immediately to reset values; no partial flags are written.

Test Plan:
- Reset: hold rst_n=0 mid-RUN after 1 word -> next cycle state IDLE, cmd_ready=1, out_valid=0, flags=4'b0100.
- ADD, 2 words, A=0x7F, B=0x01 (words lo first: a=F,b=1 then a=7,b=0), ALU model ideal -> out_y=0x0 then 0x8, carry chained (second alu_cin=1), out_last on 2nd word, flags N=1 Z=0 C=0 V=1, flags_valid one pulse.
- SUB, 1 word, A=3, B=3 -> alu_cin=1, out_y=0, flags N=0 Z=1 C=1 V=0.
- AND, 3 words, A=0xF0F, B=0x0F0 -> out_y=0,0,0, flags 4'b0100, alu_cin=0 every beat.
- Backpressure: ADD 4 words, out_ready=0 for 3 cycles after first word -> in_ready=0 during stall, out_y held, no word lost or duplicated, output order preserved.
- Command while busy: cmd_valid pulsed during RUN and DRAIN -> ignored; the next command is accepted only one cycle after the last word handshake.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Multi-word sequencer for the lab ALU: streams operand words LSW first, chains
// carry between words, returns result words over valid/ready and captures NZCV.
module alu_seq_ctrl #(
  parameter int WIDTH     = 4,
  parameter int MAX_WORDS = 4,
  localparam int LW       = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LW-1:0]    cmd_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cout,
  input  logic             alu_v,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_last,
  output logic [3:0]       flags,
  output logic             flags_valid
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_DRAIN = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [LW-1:0]    len_q, len_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             zacc_q, zacc_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_y_q, out_y_d;
  logic             out_last_q, out_last_d;
  logic [3:0]       flags_q, flags_d;
  logic             flags_valid_q, flags_valid_d;

  logic is_arith;
  logic in_beat;
  logic out_fire;
  logic last_beat;

  // Logic ops carry no meaningful C/V, so both are forced low for them.
  function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] y,
                                            input logic zacc,
                                            input logic arith,
                                            input logic cout,
                                            input logic v);
    pack_flags = {y[WIDTH-1], zacc && (y == '0), arith && cout, arith && v};
  endfunction

  assign is_arith  = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign cmd_ready = (state_q == S_IDLE);
  assign in_ready  = (state_q == S_RUN) && (!out_valid_q || out_ready);
  assign in_beat   = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign last_beat = (cnt_q == len_q);

  assign alu_a       = in_a;
  assign alu_b       = in_b;
  assign alu_op      = op_q;
  assign alu_cin     = is_arith && carry_q;
  assign out_valid   = out_valid_q;
  assign out_y       = out_y_q;
  assign out_last    = out_last_q;
  assign flags       = flags_q;
  assign flags_valid = flags_valid_q;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    carry_d       = carry_q;
    zacc_d        = zacc_q;
    out_valid_d   = out_valid_q;
    out_y_d       = out_y_q;
    out_last_d    = out_last_q;
    flags_d       = flags_q;
    flags_valid_d = 1'b0;

    if (out_fire) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          len_d   = cmd_len;
          cnt_d   = '0;
          zacc_d  = 1'b1;
          carry_d = (cmd_op == OP_SUB);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (in_beat) begin
          out_y_d     = alu_y;
          out_valid_d = 1'b1;
          out_last_d  = last_beat;
          carry_d     = alu_cout;
          zacc_d      = zacc_q && (alu_y == '0);
          cnt_d       = cnt_q + LW'(1);
          if (last_beat) begin
            flags_d       = pack_flags(alu_y, zacc_q, is_arith, alu_cout, alu_v);
            flags_valid_d = 1'b1;
            state_d       = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Only the final word can be in the output register here.
        if (out_fire) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      op_q          <= 2'b00;
      len_q         <= '0;
      cnt_q         <= '0;
      carry_q       <= 1'b0;
      zacc_q        <= 1'b1;
      out_valid_q   <= 1'b0;
      out_y_q       <= '0;
      out_last_q    <= 1'b0;
      flags_q       <= 4'b0100;
      flags_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      carry_q       <= carry_d;
      zacc_q        <= zacc_d;
      out_valid_q   <= out_valid_d;
      out_y_q       <= out_y_d;
      out_last_q    <= out_last_d;
      flags_q       <= flags_d;
      flags_valid_q <= flags_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: ideal ALU model, full-width reference arithmetic and
// a result-word / flag scoreboard.
module tb_alu_seq_ctrl;

  localparam int W  = 4;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [LW-1:0] cmd_len;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_a, in_b;
  logic [W-1:0]  alu_a, alu_b, alu_y;
  logic [1:0]    alu_op;
  logic          alu_cin, alu_cout, alu_v;
  logic          out_valid, out_ready, out_last;
  logic [W-1:0]  out_y;
  logic [3:0]    flags;
  logic          flags_valid;

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;
  logic [W:0] exp_q[$];
  logic [3:0] flg_q[$];

  always #5 clk = ~clk;

  alu_seq_ctrl #(.WIDTH(W), .MAX_WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_y(alu_y), .alu_cout(alu_cout), .alu_v(alu_v),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_last(out_last),
    .flags(flags), .flags_valid(flags_valid)
  );

  // Ideal lab ALU
  logic [W:0] s;
  always_comb begin
    s        = '0;
    alu_y    = '0;
    alu_cout = 1'b0;
    alu_v    = 1'b0;
    case (alu_op)
      2'd0: begin
        s        = {1'b0, alu_a} + {1'b0, alu_b} + 5'(alu_cin);
        alu_y    = s[W-1:0];
        alu_cout = s[W];
        alu_v    = (alu_a[W-1] == alu_b[W-1]) && (s[W-1] != alu_a[W-1]);
      end
      2'd1: begin
        s        = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'(alu_cin);
        alu_y    = s[W-1:0];
        alu_cout = s[W];
        alu_v    = (alu_a[W-1] != alu_b[W-1]) && (s[W-1] != alu_a[W-1]);
      end
      2'd2:    alu_y = alu_a & alu_b;
      default: alu_y = alu_a | alu_b;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (flags_valid) begin
        fv_cnt++;
        check_eq("fv_align", {30'd0, out_valid, out_last}, 32'd3);
        if (flg_q.size() == 0) check_eq("flags_underflow", flg_q.size(), 1);
        else check_eq("flags", flags, flg_q.pop_front());
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_eq("sb_underflow", exp_q.size(), 1);
        else check_eq("out_word", {out_last, out_y}, exp_q.pop_front());
      end
    end
  end

  task automatic run_op(input logic [1:0] op, input int len, input logic [31:0] a,
                        input logic [31:0] b, input bit stall, input bit busy);
    int n, nb, t, fv0;
    logic [31:0] mask, aa, bb, full, res;
    logic nf, zf, c, v;
    n    = len + 1;
    nb   = n * W;
    mask = (32'd1 << nb) - 1;
    aa   = a & mask;
    bb   = b & mask;
    case (op)
      2'd0:    full = aa + bb;
      2'd1:    full = aa + (~bb & mask) + 1;
      2'd2:    full = aa & bb;
      default: full = aa | bb;
    endcase
    res = full & mask;
    c   = (op < 2) ? full[nb] : 1'b0;
    nf  = res[nb-1];
    zf  = (res == 0);
    if (op == 2'd0)      v = (aa[nb-1] == bb[nb-1]) && (nf != aa[nb-1]);
    else if (op == 2'd1) v = (aa[nb-1] != bb[nb-1]) && (nf != aa[nb-1]);
    else                 v = 1'b0;
    flg_q.push_back({nf, zf, c, v});
    fv0 = fv_cnt;

    t = 0;
    while (!cmd_ready && t < 100) begin @(posedge clk); #1; t++; end
    check_eq("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_len = LW'(len);
    @(posedge clk); #1;
    // Spurious commands while busy must be ignored.
    cmd_valid = busy; cmd_op = 2'd3; cmd_len = '0;
    check_eq("cmd_ready_run", cmd_ready, 0);

    for (int i = 0; i < n; i++) begin
      logic [31:0] mi, cexp;
      mi = (32'd1 << (i * W)) - 1;
      case (op)
        2'd0:    cexp = ((aa & mi) + (bb & mi)) >> (i * W);
        2'd1:    cexp = ((aa & mi) + (~bb & mi) + 1) >> (i * W);
        default: cexp = 0;
      endcase
      in_valid = 1'b1;
      in_a = W'(aa >> (i * W));
      in_b = W'(bb >> (i * W));
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 100) begin @(negedge clk); t++; end
      if (!in_ready) begin
        check_eq("in_ready_timeout", in_ready, 1);
        break;
      end
      check_eq("alu_cin", alu_cin, cexp);
      check_eq("alu_a", alu_a, in_a);
      exp_q.push_back({(i == len), W'(res >> (i * W))});
      @(posedge clk); #1;
      check_eq("lat_valid", out_valid, 1);
      if (stall && i == 0 && n > 1) begin
        out_ready = 1'b0;
        in_a = W'(aa >> W);
        in_b = W'(bb >> W);
        repeat (3) begin
          @(negedge clk);
          check_eq("stall_in_ready", in_ready, 0);
          check_eq("stall_hold", {out_valid, out_y}, {1'b1, W'(res)});
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    end
    in_valid = 1'b0;

    t = 0;
    @(negedge clk);
    while (!(out_valid && out_ready && out_last) && t < 100) begin @(negedge clk); t++; end
    check_eq("last_seen", {31'd0, out_valid && out_last}, 1);
    check_eq("cmd_ready_drain", cmd_ready, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("cmd_ready_back", cmd_ready, 1);
    check_eq("fv_pulses", fv_cnt - fv0, 1);
    check_eq("flags_hold", flags, {nf, zf, c, v});
    check_eq("sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    @(negedge clk);
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_flags", flags, 4'b0100);
    check_eq("rst_out", {out_valid, out_last, flags_valid, in_ready, out_y}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Abort mid-RUN after one accepted word.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_len = 2'd1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    in_valid = 1'b1; in_a = 4'hF; in_b = 4'h1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("abort_cmd_ready", cmd_ready, 1);
    check_eq("abort_out_valid", out_valid, 0);
    check_eq("abort_flags", flags, 4'b0100);
    check_eq("abort_misc", {flags_valid, in_ready, out_y}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(2'd0, 1, 32'h7F, 32'h01, 1'b0, 1'b0);
    run_op(2'd1, 0, 32'h3, 32'h3, 1'b0, 1'b0);
    run_op(2'd2, 2, 32'hF0F, 32'h0F0, 1'b0, 1'b0);
    run_op(2'd0, 3, 32'h1234, 32'hFEDC, 1'b1, 1'b0);
    run_op(2'd3, 1, 32'hA5, 32'h0F, 1'b0, 1'b1);
    run_op(2'd1, 0, 32'h2, 32'h5, 1'b0, 1'b1);
    run_op(2'd1, 2, 32'h800, 32'h001, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      run_op(2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom, $urandom,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
